mandel_frame_scheduler: RTL and testbench

Sequences Mandelbrot frame rendering between the AXI-Lite register file and the pixel packer. Snapshots the frame configuration at each frame start and dispatches raster pixel coordinates round-robin to NUM_ENGINES iteration engines. Retires engine results strictly in raster order, with first/last_x/last_y markers, to the colour-map/packer stage.

---
 rtl/mandel_frame_scheduler.sv | 177 +++++++++++++++++
 tb/tb_mandel_frame_scheduler.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mandel_frame_scheduler.sv
// Mandelbrot frame scheduler: snapshots frame config, dispatches raster pixels round-robin to
// iteration engines and retires their results in raster order with frame markers.
module mandel_frame_scheduler #(
    parameter int unsigned NUM_ENGINES = 4,
    parameter int unsigned X_SIZE      = 640,
    parameter int unsigned Y_SIZE      = 480,
    parameter int unsigned ITER_W      = 16
) (
    input  logic                          out_stream_aclk,
    input  logic                          periph_resetn,
    input  logic                          cfg_enable,
    input  logic [31:0]                   cfg_iter_max,
    input  logic [31:0]                   cfg_zoom,
    input  logic [31:0]                   cfg_x_offset,
    input  logic [31:0]                   cfg_y_offset,
    output logic [31:0]                   frame_iter_max,
    output logic [31:0]                   frame_zoom,
    output logic [31:0]                   frame_x_offset,
    output logic [31:0]                   frame_y_offset,
    output logic [NUM_ENGINES-1:0]        eng_start,
    output logic [$clog2(X_SIZE)-1:0]     eng_x,
    output logic [$clog2(Y_SIZE)-1:0]     eng_y,
    input  logic [NUM_ENGINES-1:0]        eng_done,
    input  logic [NUM_ENGINES*ITER_W-1:0] eng_iter,
    output logic [ITER_W-1:0]             pix_iter,
    output logic                          pix_valid,
    input  logic                          pix_ready,
    output logic                          pix_first,
    output logic                          pix_last_x,
    output logic                          pix_last_y,
    output logic                          frame_busy,
    output logic [15:0]                   frame_count
);
    localparam int unsigned XW = $clog2(X_SIZE);
    localparam int unsigned YW = $clog2(Y_SIZE);
    localparam int unsigned PW = $clog2(NUM_ENGINES);
    localparam logic [XW-1:0] XLast = XW'(X_SIZE - 1);
    localparam logic [YW-1:0] YLast = YW'(Y_SIZE - 1);

    typedef enum logic [1:0] {StIdle, StLatch, StRun, StDrain} state_e;
    typedef enum logic [1:0] {SlotFree, SlotBusy, SlotDone} slot_e;

    state_e                 r_state;
    state_e                 w_state_d;
    slot_e                  r_slot   [NUM_ENGINES];
    logic [ITER_W-1:0]      r_result [NUM_ENGINES];
    logic [PW-1:0]          r_dptr;
    logic [PW-1:0]          r_rptr;
    logic [XW-1:0]          r_dx;
    logic [YW-1:0]          r_dy;
    logic [XW-1:0]          r_rx;
    logic [YW-1:0]          r_ry;
    logic [NUM_ENGINES-1:0] r_eng_start;
    logic [XW-1:0]          r_eng_x;
    logic [YW-1:0]          r_eng_y;
    logic [31:0]            r_frame_iter_max;
    logic [31:0]            r_frame_zoom;
    logic [31:0]            r_frame_x_offset;
    logic [31:0]            r_frame_y_offset;
    logic [15:0]            r_frame_count;

    logic w_dispatch;
    logic w_disp_last;
    logic w_pix_valid;
    logic w_retire;
    logic w_ret_last;

    always_comb begin
        w_dispatch  = (r_state == StRun) && (r_slot[r_dptr] == SlotFree);
        w_disp_last = (r_dx == XLast) && (r_dy == YLast);
        w_pix_valid = (r_slot[r_rptr] == SlotDone);
        w_retire    = w_pix_valid && pix_ready;
        w_ret_last  = (r_rx == XLast) && (r_ry == YLast);
    end

    always_ff @(posedge out_stream_aclk) begin
        if (!periph_resetn) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_d;
        end
    end

    always_comb begin
        w_state_d = r_state;
        unique case (r_state)
            StIdle:  if (cfg_enable) w_state_d = StLatch;
            StLatch: w_state_d = StRun;
            StRun:   if (w_dispatch && w_disp_last) w_state_d = StDrain;
            StDrain: if (w_retire && w_ret_last) w_state_d = cfg_enable ? StLatch : StIdle;
            default: w_state_d = StIdle;
        endcase
    end

    always_ff @(posedge out_stream_aclk) begin
        if (!periph_resetn) begin
            r_dptr           <= '0;
            r_rptr           <= '0;
            r_dx             <= '0;
            r_dy             <= '0;
            r_rx             <= '0;
            r_ry             <= '0;
            r_eng_start      <= '0;
            r_eng_x          <= '0;
            r_eng_y          <= '0;
            r_frame_iter_max <= '0;
            r_frame_zoom     <= '0;
            r_frame_x_offset <= '0;
            r_frame_y_offset <= '0;
            r_frame_count    <= '0;
            for (int k = 0; k < NUM_ENGINES; k++) begin
                r_slot[k]   <= SlotFree;
                r_result[k] <= '0;
            end
        end else begin
            r_eng_start <= '0;
            if (w_dispatch) begin
                r_eng_start <= NUM_ENGINES'(1) << r_dptr;
                r_eng_x     <= r_dx;
                r_eng_y     <= r_dy;
                r_dptr      <= r_dptr + PW'(1);
                if (r_dx == XLast) begin
                    r_dx <= '0;
                    r_dy <= (r_dy == YLast) ? '0 : r_dy + YW'(1);
                end else begin
                    r_dx <= r_dx + XW'(1);
                end
            end

            if (w_retire) begin
                r_rptr <= r_rptr + PW'(1);
                if (r_rx == XLast) begin
                    r_rx <= '0;
                    r_ry <= (r_ry == YLast) ? '0 : r_ry + YW'(1);
                end else begin
                    r_rx <= r_rx + XW'(1);
                end
                if (w_ret_last) r_frame_count <= r_frame_count + 16'd1;
            end

            if (r_state == StLatch) begin
                r_frame_iter_max <= cfg_iter_max;
                r_frame_zoom     <= cfg_zoom;
                r_frame_x_offset <= cfg_x_offset;
                r_frame_y_offset <= cfg_y_offset;
            end

            // Each slot transition is keyed on a distinct current state, so they never collide.
            for (int k = 0; k < NUM_ENGINES; k++) begin
                if (w_dispatch && (r_dptr == PW'(k))) begin
                    r_slot[k] <= SlotBusy;
                end else if (eng_done[k] && (r_slot[k] == SlotBusy)) begin
                    r_slot[k]   <= SlotDone;
                    r_result[k] <= eng_iter[k*ITER_W +: ITER_W];
                end else if (w_retire && (r_rptr == PW'(k))) begin
                    r_slot[k] <= SlotFree;
                end
            end
        end
    end

    assign frame_iter_max = r_frame_iter_max;
    assign frame_zoom     = r_frame_zoom;
    assign frame_x_offset = r_frame_x_offset;
    assign frame_y_offset = r_frame_y_offset;
    assign frame_count    = r_frame_count;
    assign frame_busy     = (r_state != StIdle);
    assign eng_start      = r_eng_start;
    assign eng_x          = r_eng_x;
    assign eng_y          = r_eng_y;
    assign pix_valid      = w_pix_valid;
    assign pix_iter       = r_result[r_rptr];
    assign pix_first      = w_pix_valid && (r_rx == '0) && (r_ry == '0);
    assign pix_last_x     = w_pix_valid && (r_rx == XLast);
    assign pix_last_y     = w_pix_valid && w_ret_last;

endmodule

// File: tb/tb_mandel_frame_scheduler.sv
// Randomised bench for mandel_frame_scheduler with a raster-order reference model and
// behavioural iteration engines of programmable latency.
module tb_mandel_frame_scheduler;
    localparam int N    = 4;
    localparam int XS   = 4;
    localparam int YS   = 2;
    localparam int IW   = 16;
    localparam int NPIX = XS * YS;

    logic          clk = 1'b0;
    logic          resetn;
    logic          cfg_enable;
    logic [31:0]   cfg_iter_max, cfg_zoom, cfg_x_offset, cfg_y_offset;
    logic [31:0]   frame_iter_max, frame_zoom, frame_x_offset, frame_y_offset;
    logic [N-1:0]  eng_start;
    logic [1:0]    eng_x;
    logic [0:0]    eng_y;
    logic [N-1:0]  eng_done = '0;
    logic [N*IW-1:0] eng_iter = '0;
    logic [IW-1:0] pix_iter;
    logic          pix_valid, pix_ready;
    logic          pix_first, pix_last_x, pix_last_y;
    logic          frame_busy;
    logic [15:0]   frame_count;

    mandel_frame_scheduler #(
        .NUM_ENGINES(N), .X_SIZE(XS), .Y_SIZE(YS), .ITER_W(IW)
    ) dut (
        .out_stream_aclk(clk),
        .periph_resetn  (resetn),
        .cfg_enable     (cfg_enable),
        .cfg_iter_max   (cfg_iter_max),
        .cfg_zoom       (cfg_zoom),
        .cfg_x_offset   (cfg_x_offset),
        .cfg_y_offset   (cfg_y_offset),
        .frame_iter_max (frame_iter_max),
        .frame_zoom     (frame_zoom),
        .frame_x_offset (frame_x_offset),
        .frame_y_offset (frame_y_offset),
        .eng_start      (eng_start),
        .eng_x          (eng_x),
        .eng_y          (eng_y),
        .eng_done       (eng_done),
        .eng_iter       (eng_iter),
        .pix_iter       (pix_iter),
        .pix_valid      (pix_valid),
        .pix_ready      (pix_ready),
        .pix_first      (pix_first),
        .pix_last_x     (pix_last_x),
        .pix_last_y     (pix_last_y),
        .frame_busy     (frame_busy),
        .frame_count    (frame_count)
    );

    initial forever #5 clk = ~clk;

    int vectors = 0;
    int errs    = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Engine models
    int          lat [N];
    bit          rand_lat = 1'b0;
    int          spur_req = 0;
    int          spur_ack = 0;
    int          spur_k;
    logic [15:0] spur_val;
    bit          e_busy [N];
    int          e_cnt  [N];
    logic [15:0] e_val  [N];

    always @(negedge clk) begin
        eng_done = '0;
        if (!resetn) begin
            for (int k = 0; k < N; k++) e_busy[k] = 1'b0;
        end else begin
            for (int k = 0; k < N; k++) begin
                if (e_busy[k]) begin
                    if (e_cnt[k] == 0) begin
                        eng_done[k]          = 1'b1;
                        eng_iter[k*IW +: IW] = e_val[k];
                        e_busy[k]            = 1'b0;
                    end else begin
                        e_cnt[k]--;
                    end
                end
            end
            if (spur_req != spur_ack && !e_busy[spur_k] && !eng_done[spur_k]) begin
                eng_done[spur_k]          = 1'b1;
                eng_iter[spur_k*IW +: IW] = spur_val;
                spur_ack++;
            end
            for (int k = 0; k < N; k++) begin
                if (eng_start[k]) begin
                    e_busy[k] = 1'b1;
                    e_cnt[k]  = rand_lat ? int'($urandom_range(7, 0)) : lat[k] - 1;
                    e_val[k]  = 16'(32'(eng_x) + XS * 32'(eng_y));
                end
            end
        end
    end

    // Reference model: dispatch and retire both walk the raster in order, engine = index mod N.
    int          m_disp = 0;
    int          m_ret  = 0;
    int          m_frames = 0;
    bit          prev_hold = 1'b0;
    logic [15:0] prev_iter;
    int          log_n = 0;
    logic [15:0] log_iter [NPIX];
    logic [2:0]  log_flag [NPIX];

    always @(negedge clk) begin
        int px;
        if (!resetn) begin
            m_disp    = 0;
            m_ret     = 0;
            m_frames  = 0;
            prev_hold = 1'b0;
        end else begin
            chk("frame_count", 32'(frame_count), 32'(m_frames & 16'hffff));
            if (eng_start != '0) begin
                px = m_disp % NPIX;
                chk("eng_start", 32'(eng_start), 32'(1) << (m_disp % N));
                chk("eng_x", 32'(eng_x), 32'(px % XS));
                chk("eng_y", 32'(eng_y), 32'(px / XS));
                if (px == 0 && m_disp != 0) chk("frame_gap", 32'(m_ret), 32'(m_disp));
                m_disp++;
                chk("inflight", 32'(m_disp - m_ret <= N), 32'd1);
            end
            if (prev_hold) begin
                chk("hold_valid", 32'(pix_valid), 32'd1);
                chk("hold_iter", 32'(pix_iter), 32'(prev_iter));
            end
            if (pix_valid) begin
                px = m_ret % NPIX;
                chk("ret_ahead", 32'(m_ret < m_disp), 32'd1);
                chk("pix_iter", 32'(pix_iter), 32'(px));
                chk("pix_first", 32'(pix_first), 32'(px == 0));
                chk("pix_last_x", 32'(pix_last_x), 32'(px % XS == XS - 1));
                chk("pix_last_y", 32'(pix_last_y), 32'(px == NPIX - 1));
                if (pix_ready) begin
                    if (log_n < NPIX) begin
                        log_iter[log_n] = pix_iter;
                        log_flag[log_n] = {pix_first, pix_last_x, pix_last_y};
                        log_n++;
                    end
                    m_ret++;
                    if (px == NPIX - 1) m_frames++;
                end
            end else begin
                chk("markers_idle", 32'({pix_first, pix_last_x, pix_last_y}), 32'd0);
            end
            prev_hold = pix_valid && !pix_ready;
            prev_iter = pix_iter;
        end
    end

    task automatic wait_ret(input int n, input int budget, input string nm);
        int c = 0;
        while (m_ret < n && c < budget) begin
            @(posedge clk);
            c++;
        end
        chk(nm, 32'(m_ret >= n), 32'd1);
    endtask

    task automatic wait_start(input int budget);
        int c = 0;
        @(negedge clk);
        while (eng_start == '0 && c < budget) begin
            @(negedge clk);
            c++;
        end
        chk("start_seen", 32'(eng_start != '0), 32'd1);
    endtask

    task automatic wait_idle(input int budget);
        int c = 0;
        @(negedge clk);
        while (frame_busy && c < budget) begin
            @(negedge clk);
            c++;
        end
        chk("idle_reached", 32'(frame_busy), 32'd0);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_start"}, 32'(eng_start), 32'd0);
        chk({tag, "_xy"}, 32'({eng_x, eng_y}), 32'd0);
        chk({tag, "_valid"}, 32'({pix_valid, pix_first, pix_last_x, pix_last_y}), 32'd0);
        chk({tag, "_iter"}, 32'(pix_iter), 32'd0);
        chk({tag, "_busy"}, 32'(frame_busy), 32'd0);
        chk({tag, "_count"}, 32'(frame_count), 32'd0);
        chk({tag, "_fzoom"}, frame_zoom, 32'd0);
        chk({tag, "_fother"}, frame_iter_max | frame_x_offset | frame_y_offset, 32'd0);
    endtask

    initial begin
        logic [2:0] exp_flag [NPIX];
        int d10;
        exp_flag = '{3'b100, 3'b000, 3'b000, 3'b010, 3'b000, 3'b000, 3'b000, 3'b011};
        resetn       = 1'b0;
        cfg_enable   = 1'b0;
        pix_ready    = 1'b1;
        cfg_iter_max = 32'h40;
        cfg_zoom     = 32'h100;
        cfg_x_offset = 32'h1234;
        cfg_y_offset = 32'h5678;
        for (int k = 0; k < N; k++) lat[k] = 3;
        repeat (3) @(posedge clk);
        #1 resetn = 1'b1;
        @(negedge clk);
        check_zero("reset");

        // Stray completion on a free slot must be ignored
        @(posedge clk);
        #1 spur_k = 2;
        spur_val = 16'hdead;
        spur_req++;
        repeat (3) @(negedge clk);
        chk("spur_free_valid", 32'(pix_valid), 32'd0);

        // Frame 1: fixed latency, config snapshot, zoom change during RUN
        @(posedge clk);
        #1 cfg_enable = 1'b1;
        wait_start(50);
        chk("first_start", 32'(eng_start), 32'd1);
        chk("first_xy", 32'({eng_x, eng_y}), 32'd0);
        chk("f_iter_max", frame_iter_max, 32'h40);
        chk("f_zoom", frame_zoom, 32'h100);
        chk("f_x_off", frame_x_offset, 32'h1234);
        chk("f_y_off", frame_y_offset, 32'h5678);
        @(posedge clk);
        #1 cfg_zoom = 32'h200;
        wait_ret(NPIX, 200, "frame1_done");
        @(negedge clk);
        chk("count_after_f1", 32'(frame_count), 32'd1);
        chk("zoom_hold", frame_zoom, 32'h100);
        @(negedge clk);
        chk("zoom_relatch", frame_zoom, 32'h200);
        chk("busy_relatch", 32'(frame_busy), 32'd1);
        for (int b = 0; b < NPIX; b++) begin
            chk("log_iter", 32'(log_iter[b]), 32'(b));
            chk("log_flag", 32'(log_flag[b]), 32'(exp_flag[b]));
        end

        // Mid-frame reset, then slow engine 0
        lat = '{12, 1, 1, 1};
        repeat (4) @(posedge clk);
        #1 resetn = 1'b0;
        @(posedge clk);
        #1 resetn = 1'b1;
        @(negedge clk);
        check_zero("midreset");
        wait_start(50);
        chk("rst_start", 32'(eng_start), 32'd1);
        chk("rst_xy", 32'({eng_x, eng_y}), 32'd0);
        repeat (6) @(negedge clk);
        chk("slot0_busy_valid", 32'(pix_valid), 32'd0);
        wait_ret(NPIX, 300, "slow_frame_done");

        // Back-pressure with all slots in flight
        cfg_enable = 1'b0;
        wait_idle(300);
        lat = '{2, 2, 2, 2};
        @(posedge clk);
        #1 pix_ready = 1'b0;
        cfg_enable = 1'b1;
        repeat (10) @(posedge clk);
        d10 = m_disp;
        #1 spur_k = 1;
        spur_val = 16'hbeef;
        spur_req++;
        repeat (10) @(posedge clk);
        chk("stall_outstanding", 32'(m_disp - m_ret), 32'd4);
        chk("stall_no_dispatch", 32'(m_disp), 32'(d10));
        #1 pix_ready = 1'b1;

        // Randomised phase
        rand_lat = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk);
            #1 pix_ready = ($urandom_range(3, 0) != 0);
            if ($urandom_range(199, 0) == 0) cfg_enable = ~cfg_enable;
            if ($urandom_range(49, 0) == 0) cfg_zoom = $urandom;
        end
        @(posedge clk);
        #1 cfg_enable = 1'b0;
        pix_ready = 1'b1;
        wait_idle(500);
        chk("final_drained", 32'(m_disp - m_ret), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule
